minmax_window_reader: RTL and testbench
=======================================

Name: minmax_window_reader

Overview:
- Controller and reader for a signed min/max tracker. The tracker has a synchronous, active-high tracker reset, one-cycle update latency and holds after reset: min = +max (0x1FFF for width 14), max = -max-1 (0x2000).
- This block drives the tracker's reset, counts a programmable window of samples, captures the tracker's extremes and computes the span.
- It presents each result on a valid/ready handshake to a register bank or streaming consumer.
- It sits directly beside the tracker in monitor and diagnostic datapaths.

Parameters:
- width, 14, sample width of the tracker extremes (signed).
- cw, 16, width of the window-length input and the internal sample counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  run windows continuously while high.
- window  input  cw  samples per window N; sampled at each window start; 0 is treated as 1.
- xmin_in  input  width  signed tracker minimum.
- xmax_in  input  width  signed tracker maximum.
- mm_reset  output  1  registered reset to tracker, active high.
- rmin  output  width  captured signed minimum.
- rmax  output  width  captured signed maximum.
- span  output  width+1  unsigned rmax - rmin.
- seq  output  8  capture counter, wraps 255 -> 0.
- valid  output  1  result available.
- ready  input  1  consumer accepts result.
- overrun  output  1  sticky: a result was overwritten before it was accepted.
- clr_ovr  input  1  synchronous clear of overrun.
- busy  output  1  high while a window is in progress.

Behaviour:
- Reset (async assert, sync release):
  - mm_reset = 1.
  - rmin, rmax, span, seq = 0; valid, overrun, busy = 0.
  - FSM enters IDLE.
- FSM states: IDLE, ACCUM, CAPT.
  - mm_reset is a registered output equal to 1 in IDLE and CAPT, and 0 in ACCUM.
- IDLE: mm_reset = 1, busy = 0. When enable is sampled high, the next state is ACCUM.
  - N_lat = max(window, 1) is latched on that edge. The counter loads N_lat - 1.
- ACCUM: mm_reset = 0, busy = 1.
  - The tracker absorbs exactly N_lat samples, on the N_lat posedges where mm_reset = 0.
  - The counter decrements each edge. When the counter is 0, the next state is CAPT.
- CAPT: one cycle, mm_reset = 1, busy = 1. On the edge leaving CAPT:
  - rmin <= xmin_in and rmax <= xmax_in.
  - span <= sign-extended (xmax_in - xmin_in), computed in width+1 bits and reinterpreted as unsigned.
  - seq increments.
  - The next state is ACCUM if enable is high (N_lat re-latched from window), otherwise IDLE.
- Window period is N_lat + 1 clocks. One input sample per window, at the CAPT edge, is discarded by design.
- Enable deasserted mid-window: the current window completes and is captured normally, then the FSM goes to IDLE. There is no abort.
- window changes mid-window: ignored until the next window start.
- Handshake:
  - valid rises on the capture edge.
  - valid falls on an edge where valid & ready, unless a capture occurs on that same edge, in which case valid stays 1 with the new data and overrun is not set.
  - rmin, rmax, span and seq are stable while valid & !ready, except when they are overwritten by a new capture.
- Overrun:
  - A capture while valid & !ready overwrites the result (newest wins) and sets overrun.
  - clr_ovr clears overrun. If clr_ovr and a new overrun occur on the same edge, set wins.
- span range: 0 .. 2^(width+1) - 1.
  - A full-scale window (-8192 .. 8191 at width 14) gives span = 16383.
  - If xmin_in > xmax_in, only possible when the tracker is mis-wired, span is the width+1 two's-complement difference taken as unsigned. No special handling.
- reset_n asserted mid-window: the window is abandoned, all outputs return to their reset values, and mm_reset = 1 immediately (async).

Test Plan:
- Ramp, no backpressure: reset, window = 4, enable = 1, ready = 1. Tracker fed -3,5,2,-7 during ACCUM. Required: mm_reset low for exactly 4 clocks; then rmin = -7, rmax = 5, span = 12, seq = 1, valid high for 1 clock; next window starts after 1 CAPT cycle (period 5).
- Window = 0: the block behaves as window = 1, giving a 2-clock period and mm_reset toggling 1/0. Each capture equals the single sample, e.g. xin = 100 gives rmin = rmax = 100, span = 0.
- Full scale: width = 14, samples 8191 and -8192 in one window of 2. Required: span = 16383, rmin = 0x2000, rmax = 0x1FFF.
- Backpressure: ready = 0 for 3 windows. Required:
  - valid stays 1.
  - Data is updated each capture; seq goes 1, 2, 3.
  - overrun sets at the second capture and stays set.
  - clr_ovr pulse clears it. Raising ready drops valid the next edge.
- Simultaneous events:
  - ready and capture on the same edge: valid stays 1 with new data, overrun stays 0.
  - clr_ovr and an overrunning capture on the same edge: overrun = 1.
- Enable and reset: with window = 10, deassert enable at ACCUM count 3; the window finishes, is captured, and the FSM goes to IDLE with mm_reset held 1. Re-enable, then pulse reset_n low mid-window: mm_reset = 1 asynchronously, and valid, seq, rmin, rmax, span, busy and overrun all go to 0.

Source files
------------

// File: rtl/minmax_window_reader.sv
// Purpose: windows a signed min/max tracker, captures its extremes and the span between them.
// Latency: tracker absorbs N samples, result is presented on the edge leaving CAPT; period N+1 clocks.
// Backpressure: valid/ready; an unaccepted result is overwritten by the next capture (newest wins) and overrun is flagged.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   enable, window        run windows continuously; samples per window (0 behaves as 1), latched at window start
//   xmin_in, xmax_in      signed extremes from the tracker
//   mm_reset              registered active-high reset to the tracker (high outside the accumulate phase)
//   rmin, rmax, span, seq captured result, unsigned span = rmax - rmin, capture counter
//   valid, ready          result handshake
//   overrun, clr_ovr      sticky overwrite flag and its synchronous clear
//   busy                  window in progress
module minmax_window_reader #(
   parameter int width = 14,
   parameter int cw    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [cw-1:0]    window,
   input  logic [width-1:0] xmin_in,
   input  logic [width-1:0] xmax_in,
   output logic             mm_reset,
   output logic [width-1:0] rmin,
   output logic [width-1:0] rmax,
   output logic [width:0]   span,
   output logic [7:0]       seq,
   output logic             valid,
   input  logic             ready,
   output logic             overrun,
   input  logic             clr_ovr,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, CAPT} state_t;

   state_t           state_q, state_d;
   logic [cw-1:0]    cnt_q, cnt_d;
   logic             mm_reset_q, mm_reset_d;
   logic             busy_q, busy_d;
   logic [width-1:0] rmin_q, rmin_d;
   logic [width-1:0] rmax_q, rmax_d;
   logic [width:0]   span_q, span_d;
   logic [7:0]       seq_q, seq_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   // Counter load value N_lat - 1, with a zero window treated as one sample.
   logic [cw-1:0]    cnt_load;
   // Span in width+1 bits so the full signed range never wraps.
   logic [width:0]   diff;
   logic             capt;

   assign cnt_load = (window == '0) ? '0 : window - cw'(1);
   assign diff     = {xmax_in[width-1], xmax_in} - {xmin_in[width-1], xmin_in};
   assign capt     = (state_q == CAPT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mm_reset_d = mm_reset_q;
      busy_d     = busy_q;
      rmin_d     = rmin_q;
      rmax_d     = rmax_q;
      span_d     = span_q;
      seq_d      = seq_q;

      case (state_q)
         IDLE: begin
            mm_reset_d = 1'b1;
            busy_d     = 1'b0;
            if (enable) begin
               state_d    = ACCUM;
               cnt_d      = cnt_load;
               mm_reset_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ACCUM: begin
            // The tracker sees mm_reset low on this edge, so the sample is still counted.
            cnt_d = cnt_q - cw'(1);
            if (cnt_q == '0) begin
               state_d    = CAPT;
               cnt_d      = '0;
               mm_reset_d = 1'b1;
            end
         end
         CAPT: begin
            rmin_d = xmin_in;
            rmax_d = xmax_in;
            span_d = diff;
            seq_d  = seq_q + 8'd1;
            if (enable) begin
               state_d    = ACCUM;
               cnt_d      = cnt_load;
               mm_reset_d = 1'b0;
               busy_d     = 1'b1;
            end else begin
               state_d    = IDLE;
               mm_reset_d = 1'b1;
               busy_d     = 1'b0;
            end
         end
         default: begin
            state_d    = IDLE;
            mm_reset_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase

      // A capture always leaves valid set, even when the consumer accepts on the same edge.
      if (capt) begin
         valid_d = 1'b1;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      // Set has priority over clear.
      if (capt && valid_q && !ready) begin
         overrun_d = 1'b1;
      end else if (clr_ovr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mm_reset_q <= 1'b1;
         busy_q     <= 1'b0;
         rmin_q     <= '0;
         rmax_q     <= '0;
         span_q     <= '0;
         seq_q      <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mm_reset_q <= mm_reset_d;
         busy_q     <= busy_d;
         rmin_q     <= rmin_d;
         rmax_q     <= rmax_d;
         span_q     <= span_d;
         seq_q      <= seq_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign mm_reset = mm_reset_q;
   assign busy     = busy_q;
   assign rmin     = rmin_q;
   assign rmax     = rmax_q;
   assign span     = span_q;
   assign seq      = seq_q;
   assign valid    = valid_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_minmax_window_reader.sv
// Purpose: self-checking bench for minmax_window_reader with a behavioural min/max tracker beside it.
// Latency: expected results are queued before each capture edge and compared when the result appears.
// Backpressure: ready is driven per scenario to exercise hold, overwrite and same-edge accept.
module tb_minmax_window_reader;

   localparam int W  = 14;
   localparam int W1 = W + 1;
   localparam int CW = 16;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable  = 1'b0;
   logic [CW-1:0] window  = '0;
   logic          ready   = 1'b0;
   logic          clr_ovr = 1'b0;
   logic [W-1:0]  xmin_in, xmax_in;
   logic          mm_reset;
   logic [W-1:0]  rmin, rmax;
   logic [W:0]    span;
   logic [7:0]    seq;
   logic          valid, overrun, busy;

   logic signed [W-1:0] x_drv = '0;
   logic signed [W-1:0] trk_min, trk_max;

   typedef struct {
      logic [W-1:0] mn;
      logic [W-1:0] mx;
      logic [W:0]   sp;
      logic [7:0]   sq;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_seq = 0;
   bit   e_vld   = 1'b0;
   bit   e_ovr   = 1'b0;
   int   smp[16];

   always #5 clk = ~clk;

   minmax_window_reader #(.width(W), .cw(CW)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .window  (window),
      .xmin_in (xmin_in),
      .xmax_in (xmax_in),
      .mm_reset(mm_reset),
      .rmin    (rmin),
      .rmax    (rmax),
      .span    (span),
      .seq     (seq),
      .valid   (valid),
      .ready   (ready),
      .overrun (overrun),
      .clr_ovr (clr_ovr),
      .busy    (busy)
   );

   // Tracker: synchronous active-high reset, one-cycle update latency.
   always @(posedge clk) begin
      if (mm_reset) begin
         trk_min <= 14'h1FFF;
         trk_max <= 14'h2000;
      end else begin
         if (x_drv < trk_min) trk_min <= x_drv;
         if (x_drv > trk_max) trk_max <= x_drv;
      end
   end
   assign xmin_in = trk_min;
   assign xmax_in = trk_max;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Result monitor: a fresh result is a rising valid or a new seq while valid.
   logic       prev_vld = 1'b0;
   logic [7:0] prev_seq = '0;
   always @(posedge clk) begin
      #1;
      if (valid === 1'b1 && (!prev_vld || seq !== prev_seq)) begin
         check_eq("sb_avail", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check_eq("rmin", 32'(rmin), 32'(mon_e.mn));
            check_eq("rmax", 32'(rmax), 32'(mon_e.mx));
            check_eq("span", 32'(span), 32'(mon_e.sp));
            check_eq("seq",  32'(seq),  32'(mon_e.sq));
         end
      end
      prev_vld = valid;
      prev_seq = seq;
   end

   // One clock; predicts valid/overrun from the inputs applied before the edge.
   task automatic step(input bit capt);
      bit nv, no;
      nv = capt ? 1'b1 : ((e_vld && ready) ? 1'b0 : e_vld);
      no = (capt && e_vld && !ready) ? 1'b1 : (clr_ovr ? 1'b0 : e_ovr);
      @(posedge clk);
      #1;
      e_vld = nv;
      e_ovr = no;
      check_eq("valid",   32'(valid),   32'(e_vld));
      check_eq("overrun", 32'(overrun), 32'(e_ovr));
   endtask

   // Called just after the edge that entered ACCUM; returns just after the capture edge.
   task automatic run_window(input int n, input int dis_at, input int rdy_capt, input bit clr_capt);
      int   mn, mx;
      exp_t e;
      mn = 8191;
      mx = -8192;
      for (int j = 0; j < n; j++) begin
         check_eq("mm_reset_accum", 32'(mm_reset), 0);
         check_eq("busy_accum",     32'(busy),     1);
         x_drv = 14'(smp[j]);
         if (smp[j] < mn) mn = smp[j];
         if (smp[j] > mx) mx = smp[j];
         if (j == dis_at) enable = 1'b0;
         step(1'b0);
      end
      check_eq("mm_reset_capt", 32'(mm_reset), 1);
      check_eq("busy_capt",     32'(busy),     1);
      // A sample presented during CAPT must never reach a result.
      x_drv = (mx < 8191) ? 14'sh1FFF : 14'sh2000;
      if (rdy_capt >= 0) ready = (rdy_capt != 0);
      if (clr_capt) clr_ovr = 1'b1;
      exp_seq = (exp_seq + 1) % 256;
      e.mn = W'(mn);
      e.mx = W'(mx);
      e.sp = W1'(mx - mn);
      e.sq = 8'(exp_seq);
      sb.push_back(e);
      step(1'b1);
      clr_ovr = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      ready   = 1'b0;
      clr_ovr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e_vld   = 1'b0;
      e_ovr   = 1'b0;
      exp_seq = 0;
      sb.delete();
      check_eq("rst_mm_reset", 32'(mm_reset), 1);
      check_eq("rst_valid",    32'(valid),    0);
      check_eq("rst_busy",     32'(busy),     0);
      check_eq("rst_overrun",  32'(overrun),  0);
      check_eq("rst_seq",      32'(seq),      0);
      check_eq("rst_rmin",     32'(rmin),     0);
      check_eq("rst_rmax",     32'(rmax),     0);
      check_eq("rst_span",     32'(span),     0);
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Ramp, no backpressure, two back-to-back windows of 4.
      do_reset();
      window = 16'd4; ready = 1'b1; enable = 1'b1;
      step(1'b0);
      smp[0] = -3; smp[1] = 5; smp[2] = 2; smp[3] = -7;
      run_window(4, -1, -1, 1'b0);
      smp[0] = 10; smp[1] = -1; smp[2] = 3; smp[3] = 0;
      run_window(4, -1, -1, 1'b0);
      // Window change mid-window takes effect only at the next start.
      window = 16'd0;
      smp[0] = 1; smp[1] = 2; smp[2] = 3; smp[3] = 4;
      run_window(4, -1, -1, 1'b0);
      // Window 0 behaves as 1: 2-clock period, capture equals the single sample.
      smp[0] = 100;
      run_window(1, -1, -1, 1'b0);
      run_window(1, -1, -1, 1'b0);
      window = 16'd2;
      smp[0] = -50;
      run_window(1, -1, -1, 1'b0);
      // Full scale in a window of 2, then let the FSM go idle.
      smp[0] = 8191; smp[1] = -8192;
      run_window(2, 0, -1, 1'b0);
      check_eq("idle_mm_reset", 32'(mm_reset), 1);
      check_eq("idle_busy",     32'(busy),     0);
      step(1'b0);
      check_eq("idle_hold_mm_reset", 32'(mm_reset), 1);

      // Backpressure over three windows.
      do_reset();
      window = 16'd3; ready = 1'b0; enable = 1'b1;
      step(1'b0);
      smp[0] = 5; smp[1] = -5; smp[2] = 7;
      run_window(3, -1, -1, 1'b0);
      check_eq("bp_ovr_first", 32'(overrun), 0);
      smp[0] = -100; smp[1] = 200; smp[2] = 0;
      run_window(3, -1, -1, 1'b0);
      check_eq("bp_ovr_second", 32'(overrun), 1);
      smp[0] = 1; smp[1] = 1; smp[2] = 1;
      run_window(3, 0, -1, 1'b0);
      check_eq("bp_ovr_third", 32'(overrun), 1);
      check_eq("bp_valid_held", 32'(valid), 1);
      clr_ovr = 1'b1;
      step(1'b0);
      clr_ovr = 1'b0;
      check_eq("bp_ovr_cleared", 32'(overrun), 0);
      ready = 1'b1;
      step(1'b0);
      check_eq("bp_valid_drop", 32'(valid), 0);

      // Same-edge events: accept with capture, then clear with overrun.
      ready = 1'b0; enable = 1'b1;
      step(1'b0);
      smp[0] = 2; smp[1] = 3; smp[2] = 4;
      run_window(3, -1, -1, 1'b0);
      smp[0] = -9; smp[1] = 30; smp[2] = 6;
      run_window(3, -1, 1, 1'b0);
      check_eq("sim_rdy_capt_valid", 32'(valid),   1);
      check_eq("sim_rdy_capt_ovr",   32'(overrun), 0);
      ready = 1'b0;
      smp[0] = 11; smp[1] = -12; smp[2] = 13;
      run_window(3, 0, -1, 1'b1);
      check_eq("sim_clr_set_ovr", 32'(overrun), 1);
      step(1'b0);

      // Enable dropped mid-window, then reset mid-window.
      do_reset();
      window = 16'd10; ready = 1'b0; enable = 1'b1;
      step(1'b0);
      smp[0] = 3;   smp[1] = -4; smp[2] = 9; smp[3] = 0; smp[4] = 12;
      smp[5] = -1;  smp[6] = 5;  smp[7] = 6; smp[8] = -20; smp[9] = 7;
      run_window(10, 6, -1, 1'b0);
      check_eq("en_idle_mm_reset", 32'(mm_reset), 1);
      check_eq("en_idle_busy",     32'(busy),     0);
      step(1'b0);
      step(1'b0);
      check_eq("en_idle_hold_mm_reset", 32'(mm_reset), 1);
      check_eq("en_idle_hold_busy",     32'(busy),     0);
      enable = 1'b1;
      step(1'b0);
      check_eq("reen_mm_reset", 32'(mm_reset), 0);
      check_eq("reen_busy",     32'(busy),     1);
      x_drv = 14'sd42;
      step(1'b0);
      step(1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_mm_reset", 32'(mm_reset), 1);
      check_eq("arst_valid",    32'(valid),    0);
      check_eq("arst_seq",      32'(seq),      0);
      check_eq("arst_rmin",     32'(rmin),     0);
      check_eq("arst_rmax",     32'(rmax),     0);
      check_eq("arst_span",     32'(span),     0);
      check_eq("arst_busy",     32'(busy),     0);
      check_eq("arst_overrun",  32'(overrun),  0);
      e_vld = 1'b0;
      e_ovr = 1'b0;
      enable = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1'b0);
      check_eq("post_rst_mm_reset", 32'(mm_reset), 1);

      check_eq("sb_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
